// File: rtl/debounce_edge_if.sv
// debounce_edge_if -- signal bundle between a debouncer and its user.
//   din  : raw asynchronous (possibly bouncing) level into the debouncer
//   D    : registered debounced level
//   rise : one-cycle pulse on a debounced 0->1 change of D
//   fall : one-cycle pulse on a debounced 1->0 change of D
//   busy : a candidate level change is being qualified
// slave  = debouncer side, master = user side.
interface debounce_edge_if;
  logic din;
  logic D;
  logic rise;
  logic fall;
  logic busy;

  modport slave  (input  din, output D, rise, fall, busy);
  modport master (output din, input  D, rise, fall, busy);
endinterface

// File: rtl/debounce_edge.sv
// debounce_edge -- synchronizer + 4-state debounce FSM with edge pulses.
// The raw level io.din is brought into the clk domain through a
// SYNC_STAGES-deep flop chain; only the last stage (s) feeds the FSM.
// A new level is accepted once s has been seen at that level on
// STABLE_CYCLES+1 consecutive edges (the entry edge plus STABLE_CYCLES
// counted edges). D, rise, fall and busy are all flop outputs.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   io    : debounce_edge_if.slave (din in; D, rise, fall, busy out)
// Parameters:
//   SYNC_STAGES   : synchronizer depth, 2..4
//   STABLE_CYCLES : stable samples required to commit, 1..255
//   CNT_W         : counter width, 2^CNT_W-1 >= STABLE_CYCLES
module debounce_edge #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_edge_if.slave  io
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------
  // Synchronizer: the only place din is sampled.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], io.din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             d_q,     d_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic             busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          // bounce back to the old level: drop the candidate
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_CNT) begin
          state_d = HIGH;
          cnt_d   = '0;
          d_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          // cnt stops at STABLE_CNT because the compare above commits first
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_CNT) begin
          state_d = LOW;
          cnt_d   = '0;
          d_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        d_d     = 1'b0;
      end
    endcase

    // busy is registered from the next state so it tracks the WAIT_* states
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  assign io.D    = d_q;
  assign io.rise = rise_q;
  assign io.fall = fall_q;
  assign io.busy = busy_q;

endmodule
